serial_subtractor: RTL

Bit-serial, multi-cycle subtractor that computes `a - b - bin`. It processes one bit per clock, LSB first, using a single full-subtractor cell, a borrow flip-flop and shift registers. It is the inverse-operation, sequential counterpart of the team's combinational 4-bit ripple-carry adder. It is used where area matters more than latency and a start/done handshake is acceptable.

---
 rtl/serial_subtractor.sv | 118 +++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
`timescale 1ns/1ps
// serial_subtractor: bit-serial a - b - bin, LSB first, one full-subtractor
// cell shared across all bit positions. start/done handshake, registered outputs.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] d_sh_q;
  logic [WIDTH-1:0] diff_q;
  logic             br_q;
  logic             borrow_q;
  logic             busy_q;
  logic             done_q;

  logic             d_bit_d;
  logic             br_d;
  logic             last_d;
  logic [WIDTH-1:0] d_sh_d;

  // One-bit full subtractor: returns {borrow_next, difference}.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic br);
    logic d;
    logic bo;
    d  = x ^ y ^ br;
    bo = (~x & y) | (~(x ^ y) & br);
    return {bo, d};
  endfunction

  // Current bit's difference/borrow and the D register as it will look after this shift.
  always_comb begin
    {br_d, d_bit_d} = full_sub(a_sh_q[0], b_sh_q[0], br_q);
    d_sh_d          = (d_sh_q >> 1) | {d_bit_d, {(WIDTH-1){1'b0}}};
    last_d          = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Control FSM plus shift datapath; outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      d_sh_q   <= '0;
      br_q     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        // DONE lasts one cycle and accepts a new request just like IDLE.
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            br_q    <= bin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          d_sh_q <= d_sh_d;
          br_q   <= br_d;
          if (last_d) begin
            // Final bit: publish the full difference, including this edge's bit.
            diff_q   <= d_sh_d;
            borrow_q <= br_d;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff_out   = diff_q;
  assign borrow_out = borrow_q;

endmodule
